bpsk_frame_sequencer: RTL and testbench
=======================================

BPSK_FRAME_SEQUENCER -- requirements
Module: bpsk_frame_sequencer

Interface
REQ-001 SHALL have parameter SAMPLES_PER_BIT, default 16, DAC samples per transmitted bit (2..255).
REQ-002 SHALL have parameter PREAMBLE_LEN, default 8, preamble bits per frame (1..16).
REQ-003 SHALL have parameter PREAMBLE_WORD, default 16'h00AA, preamble pattern; bit PREAMBLE_LEN-1 is sent first.
REQ-004 SHALL have parameter PAYLOAD_LEN, default 64, payload bits per frame (1..1023).
REQ-005 SHALL have parameter GUARD_CYCLES, default 32, idle clk cycles after the last bit.
REQ-006 SHALL have parameter DAC_TIMEOUT, default 1023, maximum clk cycles spent in any wait state.
REQ-007 SHALL have port clk  input  1  single clock, rising edge; all logic runs on it.
REQ-008 SHALL have port n_reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port start  input  1  frame request; sampled only in IDLE.
REQ-010 SHALL have ports data_in / data_valid  input  1/1  payload bit and its valid flag.
REQ-011 SHALL have port data_ready  output  1  one-cycle pulse when data_in is consumed.
REQ-012 SHALL have ports sine_rdy  input  1 (sample ready); sine_clk_en, sine_rst  output  1/1  sine datapath control.
REQ-013 SHALL have ports mod_en, tx_bit  output  1/1  modulation enable and the current bit.
REQ-014 SHALL have ports dacdav  output  1 (sample valid to DAC); davdac  input  1 (DAC acknowledge).
REQ-015 SHALL have ports en_awgn, busy, frame_done, dac_err  output  1 each  noise enable, frame active, end pulse, sticky timeout.

Function
REQ-016 SHALL implement states IDLE, PREAMBLE, PAYLOAD, GUARD; bit sub-states LOAD, SAMP_REQ, WAIT_SINE, DAC_REQ.
REQ-017 In IDLE, start=1 SHALL move the FSM to PREAMBLE/SAMP_REQ on the next edge; start is ignored in all other states.
REQ-018 sine_rst SHALL be 1 in IDLE and GUARD and 0 otherwise; busy SHALL be 1 in every state except IDLE.
REQ-019 mod_en SHALL be 1 in PREAMBLE and PAYLOAD; tx_bit SHALL remain constant for all SAMPLES_PER_BIT samples of a bit.
REQ-020 Each sample: sine_clk_en=1 for exactly one cycle (SAMP_REQ); WAIT_SINE until sine_rdy=1; DAC_REQ holds dacdav=1 until davdac=1; dacdav drops on the following cycle.
REQ-021 After SAMPLES_PER_BIT acknowledged samples, the FSM SHALL advance to the next bit; the sample counter SHALL wrap to 0.
REQ-022 Preamble bit k (k=0 first) SHALL equal PREAMBLE_WORD[PREAMBLE_LEN-1-k].
REQ-023 Each payload bit SHALL start in LOAD: while data_valid=0, the FSM waits with no sine_clk_en; when data_valid=1, data_ready pulses for one cycle and data_in is latched into tx_bit.
REQ-024 After PAYLOAD_LEN payload bits, the FSM SHALL enter GUARD for GUARD_CYCLES cycles with mod_en=0, then return to IDLE with frame_done=1 for one cycle.
REQ-025 A wait counter SHALL run in WAIT_SINE, DAC_REQ and payload LOAD; on reaching DAC_TIMEOUT: set dac_err, drop dacdav, go to IDLE, and do not assert frame_done.
REQ-026 If a handshake input arrives in the same cycle as the timeout, the handshake SHALL win and no error is raised.
REQ-027 dac_err SHALL stay set until n_reset; it SHALL NOT block a new start.

Reset
REQ-028 While n_reset=0: state IDLE; all counters 0; sine_rst=1; all other outputs 0 (including dac_err).
REQ-029 Asserting n_reset mid-frame SHALL abort the frame immediately, with no frame_done and no further data_ready.

Configuration
REQ-030 With BPSK_SEQ_AWGN_EN defined, en_awgn SHALL equal mod_en, registered with the same timing.
REQ-031 Without BPSK_SEQ_AWGN_EN, en_awgn SHALL be constant 0 and no noise-related logic is generated.

Verification
REQ-032 Params SPB=2, PREAMBLE_LEN=4, WORD=4'b1010, PAYLOAD_LEN=3, davdac one cycle after dacdav; start -> tx_bit 1,0,1,0 then payload; 14 dacdav pulses; frame_done once.
REQ-033 Payload 1,1,0 with data_valid low for 5 cycles before bit 2 -> exactly 3 data_ready pulses; no sine_clk_en during the stall; tx_bit sequence 1,1,0.
REQ-034 davdac held at 0 with DAC_TIMEOUT=10 -> dacdav high for 10 cycles, then dac_err=1, state IDLE, no frame_done; a following start runs a full frame.
REQ-035 n_reset pulsed during the second payload bit -> all outputs at reset values in the same cycle (asynchronous); a later start restarts from preamble bit 0.
REQ-036 start pulsed during GUARD and during PAYLOAD -> ignored; exactly one frame_done per accepted start.
REQ-037 Run REQ-032 with and without BPSK_SEQ_AWGN_EN -> en_awgn tracks mod_en when defined; en_awgn stays 0 when undefined.

Source files
------------

// File: rtl/bpsk_frame_sequencer.sv
// BPSK frame sequencer: sends a preamble and a payload bit by bit. Each bit is
// SAMPLES_PER_BIT sine/DAC handshakes. A guard gap and a frame_done pulse follow.
// Optional feature macro: BPSK_SEQ_AWGN_EN (drives en_awgn alongside mod_en).
module bpsk_frame_sequencer #(
    parameter int unsigned SAMPLES_PER_BIT = 16,
    parameter int unsigned PREAMBLE_LEN    = 8,
    parameter logic [15:0] PREAMBLE_WORD   = 16'h00AA,
    parameter int unsigned PAYLOAD_LEN     = 64,
    parameter int unsigned GUARD_CYCLES    = 32,
    parameter int unsigned DAC_TIMEOUT     = 1023
) (
    input  logic clk,
    input  logic n_reset,
    input  logic start,
    input  logic data_in,
    input  logic data_valid,
    output logic data_ready,
    input  logic sine_rdy,
    output logic sine_clk_en,
    output logic sine_rst,
    output logic mod_en,
    output logic tx_bit,
    output logic dacdav,
    input  logic davdac,
    output logic en_awgn,
    output logic busy,
    output logic frame_done,
    output logic dac_err
);

    localparam int unsigned SAMP_W  = 8;
    localparam int unsigned BIT_W   = 10;
    localparam int unsigned GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int unsigned WAIT_W  = (DAC_TIMEOUT > 1) ? $clog2(DAC_TIMEOUT) : 1;

    localparam logic [SAMP_W-1:0]  SAMP_LAST  = SAMP_W'(SAMPLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   PRE_LAST   = BIT_W'(PREAMBLE_LEN - 1);
    localparam logic [BIT_W-1:0]   PAY_LAST   = BIT_W'(PAYLOAD_LEN - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(DAC_TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_PAYLOAD, ST_GUARD} frame_state_t;
    typedef enum logic [1:0] {SUB_LOAD, SUB_SAMP_REQ, SUB_WAIT_SINE, SUB_DAC_REQ} bit_state_t;

    frame_state_t       state_q, state_d;
    bit_state_t         sub_q, sub_d;
    logic [SAMP_W-1:0]  samp_cnt_q, samp_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               tx_bit_d, dac_err_d, data_ready_d, frame_done_d;
    logic               sine_clk_en_d, sine_rst_d, mod_en_d, dacdav_d, busy_d;
    logic               timeout;

    // Preamble bit k, MSB of the used field first.
    function automatic logic preamble_bit(input logic [3:0] k);
        logic [3:0] idx;
        idx = 4'(PREAMBLE_LEN - 1) - k;
        return PREAMBLE_WORD[idx];
    endfunction

    // State register and registered outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            sub_q       <= SUB_LOAD;
            samp_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            guard_cnt_q <= '0;
            wait_cnt_q  <= '0;
            tx_bit      <= 1'b0;
            dac_err     <= 1'b0;
            data_ready  <= 1'b0;
            frame_done  <= 1'b0;
            sine_clk_en <= 1'b0;
            sine_rst    <= 1'b1;
            mod_en      <= 1'b0;
            dacdav      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            samp_cnt_q  <= samp_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            tx_bit      <= tx_bit_d;
            dac_err     <= dac_err_d;
            data_ready  <= data_ready_d;
            frame_done  <= frame_done_d;
            sine_clk_en <= sine_clk_en_d;
            sine_rst    <= sine_rst_d;
            mod_en      <= mod_en_d;
            dacdav      <= dacdav_d;
            busy        <= busy_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they line up with it.
    always_comb begin
        state_d      = state_q;
        sub_d        = sub_q;
        samp_cnt_d   = samp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        guard_cnt_d  = guard_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        tx_bit_d     = tx_bit;
        dac_err_d    = dac_err;
        data_ready_d = 1'b0;
        frame_done_d = 1'b0;
        timeout      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_PREAMBLE;
                    sub_d      = SUB_SAMP_REQ;
                    samp_cnt_d = '0;
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                    tx_bit_d   = preamble_bit(4'd0);
                end
            end
            ST_GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    state_d      = ST_IDLE;
                    guard_cnt_d  = '0;
                    tx_bit_d     = 1'b0;
                    frame_done_d = 1'b1;
                end else begin
                    guard_cnt_d = guard_cnt_q + GUARD_W'(1);
                end
            end
            ST_PREAMBLE, ST_PAYLOAD: begin
                unique case (sub_q)
                    SUB_LOAD: begin
                        if (data_valid) begin
                            data_ready_d = 1'b1;
                            tx_bit_d     = data_in;
                            sub_d        = SUB_SAMP_REQ;
                            wait_cnt_d   = '0;
                        end else if (wait_cnt_q == WAIT_LAST) begin
                            timeout = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end
                    SUB_SAMP_REQ: begin
                        sub_d      = SUB_WAIT_SINE;
                        wait_cnt_d = '0;
                    end
                    SUB_WAIT_SINE: begin
                        if (sine_rdy) begin
                            sub_d      = SUB_DAC_REQ;
                            wait_cnt_d = '0;
                        end else if (wait_cnt_q == WAIT_LAST) begin
                            timeout = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end
                    SUB_DAC_REQ: begin
                        if (davdac) begin
                            wait_cnt_d = '0;
                            if (samp_cnt_q != SAMP_LAST) begin
                                samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                                sub_d      = SUB_SAMP_REQ;
                            end else begin
                                samp_cnt_d = '0;
                                if (state_q == ST_PREAMBLE) begin
                                    if (bit_cnt_q == PRE_LAST) begin
                                        state_d   = ST_PAYLOAD;
                                        sub_d     = SUB_LOAD;
                                        bit_cnt_d = '0;
                                    end else begin
                                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                                        sub_d     = SUB_SAMP_REQ;
                                        tx_bit_d  = preamble_bit(bit_cnt_d[3:0]);
                                    end
                                end else if (bit_cnt_q == PAY_LAST) begin
                                    bit_cnt_d = '0;
                                    sub_d     = SUB_LOAD;
                                    if (GUARD_CYCLES == 0) begin
                                        state_d      = ST_IDLE;
                                        tx_bit_d     = 1'b0;
                                        frame_done_d = 1'b1;
                                    end else begin
                                        state_d     = ST_GUARD;
                                        guard_cnt_d = '0;
                                    end
                                end else begin
                                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                                    sub_d     = SUB_LOAD;
                                end
                            end
                        end else if (wait_cnt_q == WAIT_LAST) begin
                            timeout = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end
                endcase
            end
        endcase

        // A stuck handshake abandons the frame silently apart from the sticky error.
        if (timeout) begin
            state_d     = ST_IDLE;
            sub_d       = SUB_LOAD;
            samp_cnt_d  = '0;
            bit_cnt_d   = '0;
            guard_cnt_d = '0;
            wait_cnt_d  = '0;
            tx_bit_d    = 1'b0;
            dac_err_d   = 1'b1;
        end

        busy_d        = (state_d != ST_IDLE);
        sine_rst_d    = (state_d == ST_IDLE) || (state_d == ST_GUARD);
        mod_en_d      = (state_d == ST_PREAMBLE) || (state_d == ST_PAYLOAD);
        sine_clk_en_d = mod_en_d && (sub_d == SUB_SAMP_REQ);
        dacdav_d      = mod_en_d && (sub_d == SUB_DAC_REQ);
    end

`ifdef BPSK_SEQ_AWGN_EN
    // Noise enable follows the modulation enable cycle for cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            en_awgn <= 1'b0;
        end else begin
            en_awgn <= mod_en_d;
        end
    end
`else
    assign en_awgn = 1'b0;
`endif

endmodule

// File: tb/tb_bpsk_frame_sequencer.sv
// Self-checking bench for bpsk_frame_sequencer: randomized sine/payload stimulus,
// frame-level reference model (expected bit list per frame and pulse counts).
module tb_bpsk_frame_sequencer;

    localparam int SPB   = 2;
    localparam int PL    = 4;
    localparam int PAY   = 3;
    localparam int GUARD = 4;
    localparam int TO    = 10;
    localparam logic [15:0] WORD = 16'h000A;
    localparam int NSAMP = (PL + PAY) * SPB;

    logic clk = 1'b0;
    logic n_reset, start, data_in, data_valid, data_ready;
    logic sine_rdy, sine_clk_en, sine_rst, mod_en, tx_bit;
    logic dacdav, davdac, en_awgn, busy, frame_done, dac_err;

    int checks = 0;
    int errors = 0;

    // Monitor records
    logic hs_q[$];
    int   dav_pulses = 0, dav_run = 0, last_dav_run = 0;
    int   dr_cnt = 0, fd_cnt = 0, sce_cnt = 0;

    // Stimulus control shared from the main sequence
    logic pay_q[$];
    int   stall_at = -1;
    int   load_seq = 0;
    bit   dac_ack_en = 1'b1;

    bpsk_frame_sequencer #(
        .SAMPLES_PER_BIT(SPB),
        .PREAMBLE_LEN   (PL),
        .PREAMBLE_WORD  (WORD),
        .PAYLOAD_LEN    (PAY),
        .GUARD_CYCLES   (GUARD),
        .DAC_TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .start      (start),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .sine_rdy   (sine_rdy),
        .sine_clk_en(sine_clk_en),
        .sine_rst   (sine_rst),
        .mod_en     (mod_en),
        .tx_bit     (tx_bit),
        .dacdav     (dacdav),
        .davdac     (davdac),
        .en_awgn    (en_awgn),
        .busy       (busy),
        .frame_done (frame_done),
        .dac_err    (dac_err)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sine source: one ready pulse 1..3 cycles after each request.
    initial begin
        int d;
        sine_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (sine_rdy) begin
                sine_rdy = 1'b0;
            end else if (sine_clk_en) begin
                d = int'($urandom_range(0, 2));
                repeat (d + 1) @(negedge clk);
                sine_rdy = 1'b1;
            end
        end
    end

    // DAC: acknowledges one cycle after seeing dacdav, unless disabled.
    initial begin
        davdac = 1'b0;
        forever begin
            @(negedge clk);
            if (davdac) begin
                davdac = 1'b0;
            end else if (dacdav && dac_ack_en) begin
                @(negedge clk);
                davdac = 1'b1;
            end
        end
    end

    // Payload source: presents pay_q bits, optionally stalling before one of them.
    initial begin
        int idx, seen, lim;
        idx = 0; seen = 0;
        data_valid = 1'b0;
        data_in    = 1'b0;
        forever begin
            @(negedge clk);
            if (load_seq != seen) begin
                seen       = load_seq;
                idx        = 0;
                data_in    = pay_q[0];
                data_valid = 1'b1;
            end else if (data_ready) begin
                idx++;
                if (idx < pay_q.size()) begin
                    if (idx == stall_at) begin
                        data_valid = 1'b0;
                        lim = 0;
                        while (hs_q.size() < (PL + idx) * SPB + 0 && lim < 300) begin
                            @(negedge clk);
                            lim++;
                        end
                        check("stall_reach_load", 32'(lim < 300), 1);
                        repeat (5) begin
                            @(negedge clk);
                            check("stall_no_sine_clk_en", sine_clk_en, 0);
                        end
                    end
                    data_in    = pay_q[idx];
                    data_valid = 1'b1;
                end else begin
                    data_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: samples a little after the falling edge.
    initial begin
        logic dav_prev;
        dav_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (dacdav && davdac) hs_q.push_back(tx_bit);
            if (dacdav && !dav_prev) dav_pulses++;
            dav_prev = dacdav;
            if (dacdav) dav_run++;
            else begin
                if (dav_run > 0) last_dav_run = dav_run;
                dav_run = 0;
            end
            if (data_ready)  dr_cnt++;
            if (frame_done)  fd_cnt++;
            if (sine_clk_en) sce_cnt++;
`ifdef BPSK_SEQ_AWGN_EN
            check("en_awgn_tracks_mod_en", en_awgn, mod_en);
`else
            check("en_awgn_zero", en_awgn, 0);
`endif
        end
    end

    task automatic load_payload(input logic [PAY-1:0] bits, input int stall);
        pay_q.delete();
        for (int i = 0; i < PAY; i++) pay_q.push_back(bits[i]);
        stall_at = stall;
        load_seq++;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full frame checked against the expected bit list; bits[0] is sent first.
    task automatic run_frame(input logic [PAY-1:0] bits, input int stall, input bit poke);
        int hs0, dr0, fd0, dp0, sc0, cyc;
        logic exp_q[$];
        logic [15:0] w;
        hs0 = hs_q.size(); dr0 = dr_cnt; fd0 = fd_cnt; dp0 = dav_pulses; sc0 = sce_cnt;
        for (int k = 0; k < PL; k++) begin
            w = WORD >> (PL - 1 - k);
            exp_q.push_back(w[0]);
        end
        for (int k = 0; k < PAY; k++) exp_q.push_back(bits[k]);

        load_payload(bits, stall);
        pulse_start();
        check("busy_after_start", busy, 1);
        if (poke) begin
            cyc = 0;
            while (dr_cnt - dr0 < 1 && cyc < 500) begin @(negedge clk); cyc++; end
            check("reach_payload", 32'(cyc < 500), 1);
            pulse_start();
            cyc = 0;
            while (!(busy && !mod_en) && cyc < 500) begin @(negedge clk); cyc++; end
            check("reach_guard", 32'(cyc < 500), 1);
            pulse_start();
        end
        cyc = 0;
        while (fd_cnt == fd0 && cyc < 2000) begin @(negedge clk); cyc++; end
        check("frame_done_seen", 32'(cyc < 2000), 1);
        repeat (GUARD + 10) @(negedge clk);
        check("idle_after_frame", busy, 0);
        check("frame_done_count", fd_cnt - fd0, 1);
        check("data_ready_count", dr_cnt - dr0, PAY);
        check("dacdav_pulses", dav_pulses - dp0, NSAMP);
        check("sine_clk_en_pulses", sce_cnt - sc0, NSAMP);
        check("handshake_count", hs_q.size() - hs0, NSAMP);
        for (int i = 0; i < NSAMP; i++)
            if (hs0 + i < hs_q.size())
                check("tx_bit_seq", hs_q[hs0 + i], exp_q[i / SPB]);
    endtask

    initial begin
        int cyc, dr0, fd0;
        n_reset = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sine_rst", sine_rst, 1);
        check("rst_mod_en", mod_en, 0);
        check("rst_dacdav", dacdav, 0);
        check("rst_dac_err", dac_err, 0);
        check("rst_frame_done", frame_done, 0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame, random payload
        run_frame(PAY'($urandom), -1, 1'b0);
        // Payload 1,1,0 with a stall before the last bit
        run_frame(3'b011, 2, 1'b0);
        // Stray starts in PAYLOAD and GUARD are ignored
        run_frame(PAY'($urandom), -1, 1'b1);

        // DAC never acknowledges: timeout
        dac_ack_en = 1'b0;
        fd0 = fd_cnt;
        load_payload(PAY'($urandom), -1);
        pulse_start();
        cyc = 0;
        while (busy && cyc < 500) begin @(negedge clk); cyc++; end
        check("timeout_returns_idle", 32'(cyc < 500), 1);
        @(negedge clk);
        check("timeout_dacdav_cycles", last_dav_run, TO);
        check("timeout_dac_err", dac_err, 1);
        check("timeout_sine_rst", sine_rst, 1);
        check("timeout_no_frame_done", fd_cnt - fd0, 0);
        dac_ack_en = 1'b1;
        repeat (3) @(negedge clk);
        run_frame(PAY'($urandom), -1, 1'b0);
        check("dac_err_sticky", dac_err, 1);

        // Asynchronous reset during the second payload bit
        dr0 = dr_cnt;
        load_payload(PAY'($urandom), -1);
        pulse_start();
        cyc = 0;
        while (dr_cnt - dr0 < 2 && cyc < 500) begin @(negedge clk); cyc++; end
        check("reach_payload_bit1", 32'(cyc < 500), 1);
        #2;
        n_reset = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_sine_rst", sine_rst, 1);
        check("async_rst_mod_en", mod_en, 0);
        check("async_rst_tx_bit", tx_bit, 0);
        check("async_rst_dacdav", dacdav, 0);
        check("async_rst_sine_clk_en", sine_clk_en, 0);
        check("async_rst_dac_err", dac_err, 0);
        check("async_rst_en_awgn", en_awgn, 0);
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        dr0 = dr_cnt; fd0 = fd_cnt;
        repeat (20) @(negedge clk);
        check("post_rst_no_data_ready", dr_cnt - dr0, 0);
        check("post_rst_no_frame_done", fd_cnt - fd0, 0);
        check("post_rst_idle", busy, 0);
        run_frame(PAY'($urandom), -1, 1'b0);

        // A few more random frames
        for (int n = 0; n < 3; n++) run_frame(PAY'($urandom), -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
